// File: rtl/seq_det_event_logger.sv
// seq_det_event_logger: turns 1001/1110 detector codes into timestamped records
// queued in a small FIFO, with saturating per-type counters and sticky flags.
module seq_det_event_logger #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] code,
    input  logic       clr,
    input  logic       evt_ready,
    output logic       evt_valid,
    output logic [8:0] evt_data,
    output logic [2:0] fifo_level,
    output logic [7:0] cnt_1001,
    output logic [7:0] cnt_1110,
    output logic       ovf,
    output logic       err
);
    logic [7:0] ts;
    logic [3:0] prev_code;
    logic [8:0] mem [FIFO_DEPTH];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic       hit_1001;
    logic       hit_1110;
    logic       illegal;
    logic       push;
    logic       pop;
    logic       full;
    logic       wr_en;
    logic       drop;

    always_comb begin
        hit_1001  = code == 4'b1001 && prev_code != 4'b1001;
        hit_1110  = code == 4'b1110;
        illegal   = !(code == 4'b0000 || code == 4'b1001 || code == 4'b1110);
        push      = hit_1001 || hit_1110;
        evt_valid = fifo_level != 3'd0;
        pop       = evt_valid && evt_ready;
        full      = fifo_level == 3'(FIFO_DEPTH);
        // a pop in the same cycle frees the slot, so a full FIFO still accepts
        wr_en     = push && (!full || pop);
        drop      = push && full && !pop;
        evt_data  = evt_valid ? mem[rd_ptr] : 9'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts         <= 8'd0;
            prev_code  <= 4'b0000;
            wr_ptr     <= 2'd0;
            rd_ptr     <= 2'd0;
            fifo_level <= 3'd0;
            cnt_1001   <= 8'd0;
            cnt_1110   <= 8'd0;
            ovf        <= 1'b0;
            err        <= 1'b0;
        end else begin
            ts         <= ts + 8'd1;
            prev_code  <= code;
            wr_ptr     <= wr_ptr + 2'(wr_en);
            rd_ptr     <= rd_ptr + 2'(pop);
            fifo_level <= fifo_level + 3'(wr_en) - 3'(pop);
            cnt_1001   <= clr ? 8'd0 : cnt_1001 + 8'(hit_1001 && cnt_1001 != 8'hff);
            cnt_1110   <= clr ? 8'd0 : cnt_1110 + 8'(hit_1110 && cnt_1110 != 8'hff);
            ovf        <= !clr && (ovf || drop);
            err        <= !clr && (err || illegal);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {hit_1110, ts};
    end
endmodule

// File: tb/tb_seq_det_event_logger.sv
// tb_seq_det_event_logger: random and directed stimulus against a queue-based
// reference model of the event logger.
module tb_seq_det_event_logger;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] code = 4'b0000;
    logic       clr = 1'b0;
    logic       evt_ready = 1'b0;
    logic       evt_valid;
    logic [8:0] evt_data;
    logic [2:0] fifo_level;
    logic [7:0] cnt_1001;
    logic [7:0] cnt_1110;
    logic       ovf;
    logic       err;

    int n_checks = 0;
    int n_errors = 0;

    logic [8:0] q[$];
    logic [7:0] m_ts;
    logic [3:0] m_prev;
    int         m_c1;
    int         m_c2;
    bit         m_ovf;
    bit         m_err;

    seq_det_event_logger #(.FIFO_DEPTH(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .code(code),
        .clr(clr),
        .evt_ready(evt_ready),
        .evt_valid(evt_valid),
        .evt_data(evt_data),
        .fifo_level(fifo_level),
        .cnt_1001(cnt_1001),
        .cnt_1110(cnt_1110),
        .ovf(ovf),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ts = 8'd0;
        m_prev = 4'b0000;
        m_c1 = 0;
        m_c2 = 0;
        m_ovf = 0;
        m_err = 0;
    endtask

    // what the coming clock edge should do, given this cycle's inputs
    task automatic model_step(input logic [3:0] c, input logic cl, input logic r);
        bit h1;
        bit h2;
        h1 = c == 4'b1001 && m_prev != 4'b1001;
        h2 = c == 4'b1110;
        if (r && q.size() > 0) void'(q.pop_front());
        if (h1 || h2) begin
            if (q.size() < 4) q.push_back({h2, m_ts});
            else m_ovf = 1;
        end
        if (h1 && m_c1 < 255) m_c1++;
        if (h2 && m_c2 < 255) m_c2++;
        if (!(c == 4'b0000 || c == 4'b1001 || c == 4'b1110)) m_err = 1;
        if (cl) begin
            m_c1 = 0;
            m_c2 = 0;
            m_ovf = 0;
            m_err = 0;
        end
        m_ts = m_ts + 8'd1;
        m_prev = c;
    endtask

    task automatic compare();
        check("evt_valid", 32'(evt_valid), 32'(q.size() != 0));
        check("evt_data", 32'(evt_data), 32'(q.size() != 0 ? q[0] : 9'd0));
        check("fifo_level", 32'(fifo_level), 32'(q.size()));
        check("cnt_1001", 32'(cnt_1001), 32'(m_c1));
        check("cnt_1110", 32'(cnt_1110), 32'(m_c2));
        check("ovf", 32'(ovf), 32'(m_ovf));
        check("err", 32'(err), 32'(m_err));
    endtask

    task automatic step(input logic [3:0] c, input logic cl, input logic r);
        code = c;
        clr = cl;
        evt_ready = r;
        model_step(c, cl, r);
        @(negedge clk);
        compare();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(evt_valid), 0);
        check({tag, "_data"}, 32'(evt_data), 0);
        check({tag, "_level"}, 32'(fifo_level), 0);
        check({tag, "_c1"}, 32'(cnt_1001), 0);
        check({tag, "_c2"}, 32'(cnt_1110), 0);
        check({tag, "_ovf"}, 32'(ovf), 0);
        check({tag, "_err"}, 32'(err), 0);
    endtask

    function automatic logic [3:0] rand_code();
        int p;
        logic [3:0] c;
        p = $urandom_range(99);
        if (p < 40) return 4'b0000;
        if (p < 70) return 4'b1001;
        if (p < 90) return 4'b1110;
        do c = 4'($urandom_range(15)); while (c == 4'b0000 || c == 4'b1001 || c == 4'b1110);
        return c;
    endfunction

    initial begin
        model_reset();
        #2;
        check_reset_outputs("rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        compare();
        // 1001 held three cycles starting at ts 5
        repeat (5) step(4'b0000, 1'b0, 1'b0);
        repeat (3) step(4'b1001, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        check("r035_cnt", 32'(cnt_1001), 1);
        check("r035_rec", 32'(evt_data), 32'({1'b0, 8'd5}));
        repeat (2) step(4'b0000, 1'b0, 1'b1);
        // single 1110 pulse consumed immediately
        while (m_ts != 8'd20) step(4'b0000, 1'b0, 1'b1);
        step(4'b1110, 1'b0, 1'b1);
        check("r036_rec", 32'(evt_data), 32'({1'b1, 8'd20}));
        step(4'b0000, 1'b0, 1'b1);
        check("r036_level", 32'(fifo_level), 0);
        check("r036_cnt", 32'(cnt_1110), 1);
        // overflow with five pulses and no consumer
        step(4'b0000, 1'b1, 1'b1);
        repeat (5) begin
            step(4'b1110, 1'b0, 1'b0);
            step(4'b0000, 1'b0, 1'b0);
        end
        check("r037_level", 32'(fifo_level), 4);
        check("r037_ovf", 32'(ovf), 1);
        check("r037_cnt", 32'(cnt_1110), 5);
        // full, push and pop together
        step(4'b0000, 1'b1, 1'b0);
        step(4'b1001, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b0);
        check("r038_level", 32'(fifo_level), 4);
        check("r038_ovf", 32'(ovf), 0);
        repeat (6) step(4'b0000, 1'b0, 1'b1);
        // illegal code then clr coinciding with a 1110 pulse
        step(4'b0110, 1'b0, 1'b0);
        check("r039_err", 32'(err), 1);
        step(4'b1110, 1'b1, 1'b0);
        check("r039_err_clr", 32'(err), 0);
        check("r039_cnt_clr", 32'(cnt_1110), 0);
        check("r039_queued", 32'(fifo_level), 1);
        // saturation of the 1001 counter across several ts wraps
        repeat (300) begin
            step(4'b1001, 1'b0, 1'($urandom_range(1)));
            step(4'b0000, 1'b0, 1'($urandom_range(1)));
        end
        check("r040_sat", 32'(cnt_1001), 255);
        // randomized traffic
        repeat (3000) step(rand_code(), 1'($urandom_range(99) < 4), 1'($urandom_range(99) < 45));
        // asynchronous reset in the middle of activity
        repeat (3) step(4'b1110, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b1001, 1'b0, 1'b0);
        check("r034_first", 32'(cnt_1001), 1);
        repeat (1500) step(rand_code(), 1'($urandom_range(99) < 4), 1'($urandom_range(99) < 60));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/seq_det_event_logger.md
SEQ_DET_EVENT_LOGGER -- requirements
Module: seq_det_event_logger

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, number of event records held; fixed power of two, 4 only.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 code  input  4  detector output code: 4'b1001 (pattern 1001), 4'b1110 (pattern 1110), 4'b0000 (none).
REQ-005 clr  input  1  synchronous clear of counters and sticky flags.
REQ-006 evt_ready  input  1  consumer accepts head record.
REQ-007 evt_valid  output  1  FIFO non-empty; head record on evt_data.
REQ-008 evt_data  output  9  head record: bit 8 = type (0 = 1001, 1 = 1110), bits 7:0 = timestamp.
REQ-009 fifo_level  output  3  records held, 0..4.
REQ-010 cnt_1001  output  8  saturating count of 1001 events.
REQ-011 cnt_1110  output  8  saturating count of 1110 events.
REQ-012 ovf  output  1  sticky: event dropped because FIFO full.
REQ-013 err  output  1  sticky: illegal code seen.

Function
REQ-014 The block SHALL keep a free-running 8-bit timestamp ts, +1 every cycle, wrapping 255 -> 0, unaffected by clr.
REQ-015 The block SHALL register code each cycle into prev_code.
REQ-016 A 1001 event SHALL fire in cycle N when code == 4'b1001 and prev_code != 4'b1001: a held 1001 level counts once.
REQ-017 A 1110 event SHALL fire in every cycle in which code == 4'b1110, with no level filtering.
REQ-018 Any code other than 0000, 1001 or 1110 SHALL fire no event and SHALL set err at the next edge.
REQ-019 On an event in cycle N, a record {type, ts value of cycle N} SHALL be written at edge N+1: evt_valid is high from cycle N+1 if the FIFO was empty, so latency is 1 cycle.
REQ-020 The FIFO SHALL be first-in first-out; evt_data SHALL equal the oldest record whenever evt_valid = 1.
REQ-021 A pop SHALL occur at the edge when evt_valid && evt_ready; evt_ready with evt_valid = 0 SHALL have no effect.
REQ-022 Push when level < 4 SHALL be accepted.
REQ-023 Push when level == 4 with no pop in the same cycle SHALL be dropped and SHALL set ovf.
REQ-024 Push and pop in the same cycle at level == 4 SHALL both succeed, leaving level at 4 with no ovf.
REQ-025 Push and pop in the same cycle at any other level SHALL leave fifo_level unchanged.
REQ-026 Pointers SHALL wrap modulo 4.
REQ-027 Counters SHALL increment by 1 per event and saturate at 255.
REQ-028 Counters SHALL increment even when the record is dropped.
REQ-029 clr SHALL zero cnt_1001, cnt_1110, ovf and err at the next edge, with priority over a same-cycle increment or flag set.
REQ-030 An event in the clr cycle SHALL still be pushed to the FIFO.
REQ-031 clr SHALL NOT alter FIFO contents, pointers, ts or prev_code.

Reset
REQ-032 rst_n low SHALL immediately force evt_valid = 0, evt_data = 0, fifo_level = 0, cnt_1001 = 0, cnt_1110 = 0, ovf = 0, err = 0, ts = 0 and prev_code = 0000.
REQ-033 Assertion mid-operation SHALL discard all stored records.
REQ-034 The first edge after deassertion SHALL sample code normally: a 1001 present at that edge counts as a new event.

Verification
REQ-035 After reset, code = 1001 held 3 cycles from ts = 5, then 0000 -> cnt_1001 = 1 and one record {0, 8'd5} with evt_valid one cycle later.
REQ-036 code = 1110 for one cycle at ts = 20, evt_ready = 1 -> evt_data = {1, 8'd20} for exactly one cycle, cnt_1110 = 1, fifo_level returns to 0.
REQ-037 evt_ready = 0, five separate 1110 pulses -> fifo_level = 4, ovf = 1, cnt_1110 = 5, and draining yields the first four timestamps in order.
REQ-038 FIFO full, 1001 edge with evt_ready = 1 the same cycle -> level stays 4, ovf stays 0, new record appears last.
REQ-039 code = 4'b0110 one cycle, then clr pulse coincident with a 1110 pulse -> err = 1, then err = 0 and cnt_1110 = 0, with the record still queued.
REQ-040 256 distinct 1001 events -> cnt_1001 saturates at 255, and ts wraps 255 -> 0 inside the recorded timestamps.
